// File: rtl/npu_mem_burst_reader.sv
// npu_mem_burst_reader: reads a burst of consecutive words from an NPU memory and streams them
// out on valid/ready, absorbing the 1-cycle RAM latency with a 2-entry return FIFO.
module npu_mem_burst_reader #(
   parameter int DEPTH    = 1024,
   parameter int WIDTH    = 21,
   parameter int MEMSEL_W = 6,
   parameter int REGSEL_W = 11
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [MEMSEL_W-1:0] start_mem,
   input  logic [REGSEL_W-1:0] start_addr,
   input  logic [REGSEL_W-1:0] len,
   output logic                busy,
   output logic                done,
   output logic [MEMSEL_W-1:0] mem_adr,
   output logic [REGSEL_W-1:0] reg_adr,
   output logic                we,
   input  logic [WIDTH-1:0]    ram_dout,
   output logic                m_valid,
   output logic [WIDTH-1:0]    m_data,
   output logic                m_last,
   input  logic                m_ready
);
   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2;
   localparam logic [REGSEL_W-1:0] MASK = REGSEL_W'(DEPTH - 1);

   logic [1:0]          state, occ;
   logic [REGSEL_W-1:0] addr, rem;
   logic                pres, pres_last, arr, arr_last;
   logic [WIDTH-1:0]    d0, d1;
   logic                l0, l1;
   logic                first, issue, pop, fpop, push;

   // A word arriving on ram_dout is forwarded directly when the FIFO is empty
   assign we      = 1'b0;
   assign busy    = state != IDLE;
   assign m_valid = occ != 2'd0 || arr;
   assign m_data  = occ != 2'd0 ? d0 : arr ? ram_dout : '0;
   assign m_last  = occ != 2'd0 ? l0 : arr & arr_last;
   assign pop     = m_valid & m_ready;
   assign fpop    = pop & (occ != 2'd0);
   assign push    = arr & ~(pop & (occ == 2'd0));
   assign first   = state == IDLE && start && len != '0;
   // Outstanding words (stored + arriving + presented) never exceed the FIFO's two entries
   assign issue   = state == RUN && rem != '0 &&
                    (3'(occ) + 3'(arr) + 3'(pres) <= 3'(pop) + 3'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         occ       <= '0;
         addr      <= '0;
         rem       <= '0;
         pres      <= 1'b0;
         pres_last <= 1'b0;
         arr       <= 1'b0;
         arr_last  <= 1'b0;
         d0        <= '0;
         d1        <= '0;
         l0        <= 1'b0;
         l1        <= 1'b0;
         done      <= 1'b0;
         mem_adr   <= '0;
         reg_adr   <= '0;
      end else begin
         done      <= state == IDLE && start && len == '0;
         pres      <= first | issue;
         pres_last <= first ? len == REGSEL_W'(1) : rem == REGSEL_W'(1);
         arr       <= pres;
         arr_last  <= pres_last;
         if (first) begin
            mem_adr <= start_mem;
            reg_adr <= start_addr & MASK;
            addr    <= (start_addr + 1'b1) & MASK;
            rem     <= len - 1'b1;
            state   <= len == REGSEL_W'(1) ? DRAIN : RUN;
         end else if (issue) begin
            reg_adr <= addr;
            addr    <= (addr + 1'b1) & MASK;
            rem     <= rem - 1'b1;
            if (rem == REGSEL_W'(1)) state <= DRAIN;
         end
         if (pop && m_last) begin
            done  <= 1'b1;
            state <= IDLE;
         end
         occ <= occ + 2'(push) - 2'(fpop);
         d0  <= fpop ? (occ == 2'd2 ? d1 : ram_dout) : (occ == 2'd0 ? ram_dout : d0);
         l0  <= fpop ? (occ == 2'd2 ? l1 : arr_last) : (occ == 2'd0 ? arr_last : l0);
         if (push && occ + 2'(!fpop) == 2'd2) begin
            d1 <= ram_dout;
            l1 <= arr_last;
         end
      end
   end
endmodule

// File: tb/tb_npu_mem_burst_reader.sv
// tb_npu_mem_burst_reader: table-driven bursts plus hand-written corner sequences, checked
// against a word-sequence model of the burst (address i of the burst yields RAM[(a+i)%DEPTH]).
module tb_npu_mem_burst_reader;
   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, m_ready = 1'b0;
   logic [5:0]  start_mem = '0;
   logic [10:0] start_addr = '0, len = '0;
   logic        busy, done, we, m_valid, m_last;
   logic [5:0]  mem_adr;
   logic [10:0] reg_adr;
   logic [20:0] ram_dout = '0, m_data;
   logic [20:0] mem [1024];
   int checks = 0, errors = 0;
   int pat [7] = '{1, 0, 0, 1, 0, 1, 1};

   typedef struct {int m; int a; int l; int mode; int poke; int exp_last;} vec_t;
   vec_t tbl [7];

   npu_mem_burst_reader dut (
      .clk(clk), .rst_n(rst_n), .start(start), .start_mem(start_mem), .start_addr(start_addr),
      .len(len), .busy(busy), .done(done), .mem_adr(mem_adr), .reg_adr(reg_adr), .we(we),
      .ram_dout(ram_dout), .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
   );

   always #5 clk = ~clk;

   // memory select folded into the data so a wrong mem_adr is visible in the stream
   always @(posedge clk) ram_dout <= mem[int'(reg_adr) % 1024] ^ {mem_adr, 15'b0};

   function automatic logic [20:0] exp_word(input int m, input int a);
      logic [5:0] ms = m[5:0];
      return mem[a % 1024] ^ {ms, 15'b0};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic run_burst(input vec_t v);
      int acc = 0, iss = 0, last_hs = -1, first_v = -1, dones = 0;
      logic [20:0] held = '0;
      logic stalled = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; start_mem = 6'(v.m); start_addr = 11'(v.a); len = 11'(v.l);
      @(posedge clk); #1;
      start = 1'b0;
      chk("first_reg_adr", reg_adr, v.a % 1024);
      chk("mem_adr", mem_adr, v.m);
      chk("busy_on", busy, 1);
      for (int cyc = 1; cyc < 3000 && dones == 0; cyc++) begin
         if (cyc > 1) begin @(posedge clk); #1; end
         start = v.poke != 0 && cyc == 3;
         if (start) begin start_addr = 11'd700; len = 11'd3; start_mem = 6'd9; end
         m_ready = v.mode == 0 ? 1'b1 : v.mode == 1 ? pat[(cyc - 1) % 7] != 0 : 1'($urandom_range(0, 1));
         if (busy && iss < v.l && int'(reg_adr) == (v.a + iss) % 1024) iss++;
         if (v.mode == 0 && cyc <= v.l) chk("issue_rate", iss, cyc);
         chk("outstanding", iss - acc <= 2, 1);
         if (v.mode == 0 && cyc >= 2 && cyc <= v.l + 1) chk("stream", m_valid, 1);
         if (stalled) chk("stall_hold", {m_valid, m_data}, {1'b1, held});
         stalled = 1'b0;
         if (m_valid) begin
            if (first_v < 0) first_v = cyc;
            chk("beat_in_range", acc < v.l, 1);
            chk("data", m_data, exp_word(v.m, v.a + acc));
            chk("last", m_last, acc == v.l - 1);
            held = m_data;
            stalled = !m_ready;
            if (m_ready) begin
               acc++;
               if (acc == v.l) last_hs = cyc;
            end
         end
         if (done) begin
            dones++;
            chk("done_time", cyc, last_hs + 1);
            chk("done_busy", busy, 0);
         end
      end
      chk("done_seen", dones, 1);
      chk("first_valid", first_v, 2);
      chk("beats", acc, v.l);
      chk("issued", iss, v.l);
      @(posedge clk); #1;
      chk("done_single", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_valid", m_valid, 0);
      chk("final_reg_adr", reg_adr, v.exp_last);
   endtask

   initial begin
      int hs, r;
      for (int i = 0; i < 1024; i++) mem[i] = 21'($urandom);
      for (int i = 0; i < 4; i++) mem[10 + i] = 21'(i + 1);
      tbl[0] = '{0, 10, 4, 0, 0, 13};
      tbl[1] = '{0, 10, 4, 1, 0, 13};
      tbl[2] = '{0, 1022, 4, 0, 0, 1};
      tbl[3] = '{5, 100, 9, 2, 0, 108};
      tbl[4] = '{3, 1000, 1030, 0, 0, 1005};
      tbl[5] = '{7, 512, 1, 1, 0, 512};
      tbl[6] = '{1, 20, 6, 2, 1, 25};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", m_valid, 0);
      chk("rst_last", m_last, 0);
      chk("rst_data", m_data, 0);
      chk("rst_adr", {mem_adr, reg_adr}, 0);
      chk("we", we, 0);
      @(negedge clk) rst_n = 1'b1;

      for (int i = 0; i < 7; i++) run_burst(tbl[i]);

      // zero-length burst
      r = int'(reg_adr);
      @(posedge clk); #1;
      start = 1'b1; start_addr = 11'd55; len = 11'd0; m_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("zl_done", done, 1);
      chk("zl_busy", busy, 0);
      chk("zl_valid", m_valid, 0);
      chk("zl_reg_adr", reg_adr, r);
      @(posedge clk); #1;
      chk("zl_done_pulse", done, 0);
      chk("zl_busy2", {busy, m_valid}, 0);

      // reset after two of eight words accepted
      start = 1'b1; start_mem = 6'd4; start_addr = 11'd200; len = 11'd8; m_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      hs = 0;
      for (int c = 0; c < 20 && hs < 2; c++) begin
         if (m_valid && m_ready) hs++;
         if (hs < 2) begin @(posedge clk); #1; end
      end
      chk("mid_hs", hs, 2);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("mid_valid", m_valid, 0);
      chk("mid_busy", busy, 0);
      chk("mid_done", done, 0);
      chk("mid_last", m_last, 0);
      chk("mid_data", m_data, 0);
      chk("mid_adr", {mem_adr, reg_adr}, 0);
      @(negedge clk) rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk("mid_no_done", {done, busy, m_valid}, 0);
      end
      run_burst('{2, 300, 3, 0, 0, 302});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
